// File: rtl/tape_pkg.sv
// Shared types and constants for the cassette playback engine.
// Holds the FSM state enum, the half-bit count per byte and the default sync byte.
package tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEADER,
        ST_SYNC,
        ST_DATA,
        ST_FINISH
    } tape_state_t;

    localparam int         HALF_BITS_PER_BYTE = 16;
    localparam logic [7:0] SYNC_BYTE_DEF      = 8'hE6;

endpackage

// File: rtl/tape_bit_enc.sv
// Manchester bit encoder: shift register, half-bit timer and output level.
// Ports: i_load/i_byte (start a fresh byte), i_ce (tick), i_freeze (hold timing),
//        o_byte_done (final tick of the last half-bit), o_tape (line level).
module tape_bit_enc
    import tape_pkg::*;
#(
    parameter logic [15:0] HALF_BIT_CYCLES = 16'd13000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_ce,
    input  logic       i_freeze,
    output logic       o_byte_done,
    output logic       o_tape
);

    localparam logic [15:0] CNT_LAST = HALF_BIT_CYCLES - 16'd1;
    localparam logic [3:0]  HB_LAST  = 4'(HALF_BITS_PER_BYTE - 1);

    logic [7:0]  r_sh;
    logic [3:0]  r_hb;
    logic [15:0] r_cnt;
    logic        w_half_end;

    assign w_half_end  = i_ce && (r_cnt == CNT_LAST);
    assign o_byte_done = w_half_end && (r_hb == HB_LAST);
    // Even half-bit carries the inverted bit, odd half-bit the true bit.
    assign o_tape      = r_hb[0] ? r_sh[7] : ~r_sh[7];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sh  <= '0;
            r_hb  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_byte;
            r_hb  <= '0;
            r_cnt <= '0;
        end else if (i_ce && !i_freeze) begin
            if (w_half_end) begin
                r_cnt <= '0;
                r_hb  <= r_hb + 4'd1;
                // Next bit comes up once both halves of the current one are out.
                if (r_hb[0]) begin
                    r_sh <= {r_sh[6:0], 1'b0};
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/tape_player.sv
// Cassette playback: streams leader, sync byte and an SDRAM image as Manchester.
// Ports: i_start/i_stop control, i_base/i_length image, o_rd_* / i_rd_* byte fetch,
//        o_tape_out line, o_busy/o_done/o_underrun status. TAPE_PAUSE_EN adds i_pause.
module tape_player
    import tape_pkg::*;
#(
    parameter logic [15:0] HALF_BIT_CYCLES = 16'd13000,
    parameter int          LEADER_BYTES    = 256,
    parameter logic [7:0]  SYNC_BYTE       = SYNC_BYTE_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ce,
    input  logic        i_start,
    input  logic        i_stop,
`ifdef TAPE_PAUSE_EN
    input  logic        i_pause,
`endif
    input  logic [24:0] i_base,
    input  logic [24:0] i_length,
    output logic        o_rd_req,
    output logic [24:0] o_rd_addr,
    input  logic [7:0]  i_rd_data,
    input  logic        i_rd_ack,
    output logic        o_tape_out,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underrun
);

    localparam logic [15:0] LB_LAST = 16'(LEADER_BYTES - 1);

    tape_state_t r_state, w_next;

    logic [24:0] r_base, r_len, r_fidx, r_rem, r_rd_addr;
    logic [15:0] r_lcnt;
    logic [7:0]  r_buf, w_byte, w_dbyte;
    logic        r_buf_v, r_stall, r_rd_req, r_underrun;
    logic        w_ce, w_bd, w_ack, w_avail, w_go, w_load;
    logic        w_take, w_stall_set, w_freeze, w_active, w_enc_tape;

`ifdef TAPE_PAUSE_EN
    assign w_ce = i_ce && !i_pause;
`else
    assign w_ce = i_ce;
`endif

    assign w_ack    = i_rd_ack && r_rd_req;
    assign w_avail  = r_buf_v || w_ack;
    assign w_dbyte  = r_buf_v ? r_buf : i_rd_data;
    assign w_freeze = r_stall || w_stall_set;

    tape_bit_enc #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_enc (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_load),
        .i_byte     (w_byte),
        .i_ce       (w_ce),
        .i_freeze   (w_freeze),
        .o_byte_done(w_bd),
        .o_tape     (w_enc_tape)
    );

    always_comb begin
        w_next      = r_state;
        w_go        = 1'b0;
        w_load      = 1'b0;
        w_byte      = 8'h00;
        w_take      = 1'b0;
        w_stall_set = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_go   = 1'b1;
                    w_load = 1'b1;
                    if (LEADER_BYTES == 0) begin
                        w_byte = SYNC_BYTE;
                        w_next = ST_SYNC;
                    end else begin
                        w_next = ST_LEADER;
                    end
                end
            end
            ST_LEADER: begin
                if (w_bd) begin
                    w_load = 1'b1;
                    if (r_lcnt == LB_LAST) begin
                        w_byte = SYNC_BYTE;
                        w_next = ST_SYNC;
                    end
                end
            end
            ST_SYNC, ST_DATA: begin
                if (r_stall) begin
                    // Stalled: the late byte goes straight into the shifter.
                    if (w_ack) begin
                        w_load = 1'b1;
                        w_byte = i_rd_data;
                        w_take = 1'b1;
                    end
                end else if (w_bd) begin
                    if (r_rem == '0) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_next = ST_DATA;
                        if (w_avail) begin
                            w_load = 1'b1;
                            w_byte = w_dbyte;
                            w_take = 1'b1;
                        end else begin
                            w_stall_set = 1'b1;
                        end
                    end
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (i_stop) begin
            w_next      = ST_IDLE;
            w_go        = 1'b0;
            w_load      = 1'b0;
            w_take      = 1'b0;
            w_stall_set = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_base     <= '0;
            r_len      <= '0;
            r_fidx     <= '0;
            r_rem      <= '0;
            r_lcnt     <= '0;
            r_buf      <= '0;
            r_buf_v    <= 1'b0;
            r_stall    <= 1'b0;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_ack) begin
                r_buf    <= i_rd_data;
                r_buf_v  <= 1'b1;
                r_rd_req <= 1'b0;
            end
            if (w_take) begin
                r_buf_v <= 1'b0;
                r_rem   <= r_rem - 25'd1;
                // One fetch in flight at a time; the next one follows each load.
                if (r_fidx != r_len) begin
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= r_base + r_fidx;
                    r_fidx    <= r_fidx + 25'd1;
                end
            end
            if (r_state == ST_LEADER && w_bd) begin
                r_lcnt <= r_lcnt + 16'd1;
            end
            if (w_stall_set) begin
                r_underrun <= 1'b1;
            end
            if (w_go || i_stop) begin
                r_stall <= 1'b0;
            end else if (w_stall_set) begin
                r_stall <= 1'b1;
            end else if (w_take) begin
                r_stall <= 1'b0;
            end
            if (w_go) begin
                r_base     <= i_base;
                r_len      <= i_length;
                r_rem      <= i_length;
                r_lcnt     <= '0;
                r_buf_v    <= 1'b0;
                r_underrun <= 1'b0;
                r_rd_req   <= (i_length != '0);
                r_rd_addr  <= i_base;
                r_fidx     <= {24'd0, (i_length != '0)};
            end
            if (i_stop) begin
                r_rd_req <= 1'b0;
            end
        end
    end

    assign w_active   = (r_state == ST_LEADER) || (r_state == ST_SYNC) ||
                        (r_state == ST_DATA);
    assign o_tape_out = w_active && w_enc_tape;
    assign o_busy     = w_active;
    assign o_done     = (r_state == ST_FINISH);
    assign o_rd_req   = r_rd_req;
    assign o_rd_addr  = r_rd_addr;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_tape_player.sv
// Self-checking bench for tape_player with a waveform reference model.
// Uses HALF_BIT_CYCLES=4, LEADER_BYTES=2, ce held high; pause test with TAPE_PAUSE_EN.
module tb_tape_player;

    localparam int H  = 4;
    localparam int L  = 2;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef TAPE_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic [24:0] base = '0;
    logic [24:0] length = '0;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic        rd_ack = 1'b0;
    logic        tape_out, busy, done, underrun;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;
    int t0 = 0;

    int lat_cur = 2;
    int slow_idx = -1;
    int slow_lat = 100;
    int wait_n = 0;
    int fetch_n = 0;
    int ack_k = BIG;
    logic [24:0] fq[$];
    logic [7:0]  mem[256];
    logic [7:0]  exp_q[$];

    tape_player #(
        .HALF_BIT_CYCLES(16'(H)),
        .LEADER_BYTES   (L),
        .SYNC_BYTE      (8'hE6)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_ce      (ce),
        .i_start   (start),
        .i_stop    (stop),
`ifdef TAPE_PAUSE_EN
        .i_pause   (pause),
`endif
        .i_base    (base),
        .i_length  (length),
        .o_rd_req  (rd_req),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .i_rd_ack  (rd_ack),
        .o_tape_out(tape_out),
        .o_busy    (busy),
        .o_done    (done),
        .o_underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt++;

    // SDRAM model: fixed latency per request, one request can be made slow.
    always @(negedge clk) begin
        if (rd_ack) begin
            rd_ack = 1'b0;
        end else if (rd_req) begin
            wait_n++;
            if (wait_n >= ((fetch_n == slow_idx) ? slow_lat : lat_cur)) begin
                rd_ack  = 1'b1;
                rd_data = mem[rd_addr[7:0]];
                fq.push_back(rd_addr);
                if (fetch_n == slow_idx) ack_k = ecnt + 1 - t0;
                fetch_n++;
                wait_n = 0;
            end
        end else begin
            wait_n = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level at tick j of an unstalled stream of exp_q bytes.
    function automatic logic lvl(input int j);
        int half, hb;
        logic [7:0] by;
        half = j / H;
        hb   = half % 16;
        by   = exp_q[half / 16];
        return (hb % 2 == 1) ? by[7 - hb / 2] : ~by[7 - hb / 2];
    endfunction

    task automatic start_pulse(input logic [24:0] b, input logic [24:0] n);
        @(negedge clk);
        base   = b;
        length = n;
        start  = 1'b1;
        t0     = ecnt + 1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_k(input int k);
        while (ecnt - t0 < k) @(negedge clk);
    endtask

    task automatic run(input logic [24:0] b, input logic [24:0] n,
                       input int slow, input int restart_k);
        int T, bnd, k, j, wave_err, done_k;
        bit saw_req;
        exp_q.delete();
        for (int i = 0; i < L; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hE6);
        for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[8'(b[7:0] + 8'(i))]);
        T        = 16 * H * exp_q.size();
        bnd      = (slow >= 0) ? 16 * H * (L + 1 + slow) : BIG;
        fq.delete();
        fetch_n  = 0;
        ack_k    = BIG;
        slow_idx = slow;
        wave_err = 0;
        done_k   = -1;
        saw_req  = 1'b0;
        start_pulse(b, n);
        for (int c = 0; c < T + 400 && done_k < 0; c++) begin
            if (c > 0) @(negedge clk);
            k = ecnt - t0;
            if (k == restart_k) begin
                start  = 1'b1;
                base   = ~b;
                length = n + 25'd3;
            end else begin
                start  = 1'b0;
            end
            if (rd_req === 1'b1) saw_req = 1'b1;
            j = (k < bnd) ? k : ((k < ack_k) ? bnd - 1 : k - (ack_k - bnd));
            if (done === 1'b1) done_k = j;
            if (j < T) begin
                if (tape_out !== lvl(j) || busy !== 1'b1 || done !== 1'b0)
                    wave_err++;
            end else if (j == T) begin
                if (tape_out !== 1'b0 || busy !== 1'b0) wave_err++;
            end
        end
        start = 1'b0;
        chk("waveform", wave_err, 0);
        chk("done_time", done_k, T);
        chk("underrun", underrun, (slow >= 0));
        chk("rd_req_seen", saw_req, (n != 0));
        chk("fetch_count", fq.size(), n);
        for (int i = 0; i < fq.size() && i < int'(n); i++)
            chk("fetch_addr", fq[i], 25'(b + 25'(i)));
        @(negedge clk);
        chk("done_pulse", {busy, done}, 0);
    endtask

    initial begin
        int bad;
        logic lv;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_tape", tape_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mem[8'h00] = 8'hA5;
        mem[8'h01] = 8'h3C;
        run(25'h100, 25'd2, -1, -1);
        run(25'h100, 25'd0, -1, -1);

        lat_cur = $urandom_range(1, 4);
        run(25'($urandom), 25'd3, 1, -1);
        run(25'h080, 25'd2, -1, 150);
        repeat (3) begin
            lat_cur = $urandom_range(1, 5);
            run(25'($urandom), 25'($urandom_range(1, 4)), -1, -1);
        end
        run(25'h1FFFFFF, 25'd3, -1, -1);

        lat_cur = 300;
        start_pulse(25'h040, 25'd2);
        wait_k(140);
        chk("stop_pre_busy", busy, 1);
        chk("stop_pre_req", rd_req, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_tape", tape_out, 0);
        chk("stop_rd_req", rd_req, 0);
        chk("stop_done", done, 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0) bad++;
        end
        chk("stop_quiet", bad, 0);
        lat_cur = 2;
        run(25'h040, 25'd2, -1, -1);

        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        bad = 0;
        repeat (20) begin
            if (busy !== 1'b0 || rd_req !== 1'b0 || tape_out !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("start_stop_same", bad, 0);

        lat_cur = 400;
        start_pulse(25'h123, 25'd2);
        wait_k(200);
        chk("mid_data_busy", busy, 1);
        chk("mid_data_underrun", underrun, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_rd_req", rd_req, 0);
        chk("rst2_rd_addr", rd_addr, 0);
        chk("rst2_tape", tape_out, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_done", done, 0);
        chk("rst2_underrun", underrun, 0);
        rst_n = 1'b1;
        lat_cur = 2;
        @(negedge clk);

`ifdef TAPE_PAUSE_EN
        start_pulse(25'h010, 25'd1);
        wait_k(20);
        lv = tape_out;
        pause = 1'b1;
        bad = 0;
        repeat (50) begin
            if (tape_out !== lv) bad++;
            @(negedge clk);
        end
        pause = 1'b0;
        chk("pause_flat", bad, 0);
        for (int c = 0; c < 1000 && done !== 1'b1; c++) @(negedge clk);
        chk("pause_done_time", ecnt - t0, 16 * H * (L + 2) + 50);
        @(negedge clk);
`else
        lv = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tape_player.md
# tape_player

Cassette playback engine that streams a tape image from SDRAM and drives the PPA1 port-C tape input bit as a Manchester-coded waveform. It is the transmitter counterpart of the ROM tape-read routine and of the PPA1 PC0 tape-out bit. It sits between the SDRAM arbiter (byte read port) and the PPA1 `ipc[4]` input. It emits a zero-byte leader, a sync byte, then `length` image bytes, and pulses `done`.

## Interface
Parameters:
- HALF_BIT_CYCLES, 16'd13000 — `ce` ticks per half-bit; must be ≥ 2.
- LEADER_BYTES, 256 — number of 0x00 leader bytes; 0 is legal and skips the leader.
- SYNC_BYTE, 8'hE6 — byte sent between leader and data.

Ports:
- clk  in  1  system clock (clk_sys); one clock; reset is synchronous and active-low.
- reset_n  in  1  synchronous active-low reset.
- ce  in  1  timing strobe; all bit timing advances only on clk edges with ce=1.
- start  in  1  one-clk pulse; begins playback when idle.
- stop  in  1  one-clk pulse; aborts playback.
- base  in  25  SDRAM byte address of the first image byte; latched on start.
- length  in  25  image byte count; latched on start.
- rd_req  out  1  byte read request; held until rd_ack.
- rd_addr  out  25  read address; stable while rd_req=1.
- rd_data  in  8  read data; valid when rd_ack=1.
- rd_ack  in  1  one-clk read acknowledge.
- tape_out  out  1  Manchester waveform to PPA1 port C bit 4.
- busy  out  1  1 from the cycle after an accepted start until done or abort.
- done  out  1  one-clk pulse after the final half-bit completes.
- underrun  out  1  sticky; set when a byte is not fetched in time; cleared on start.

## Operation
- States: IDLE, LEADER, SYNC, DATA, FINISH.
- IDLE: tape_out=0, busy=0. On start, latch base and length, clear underrun, issue the first fetch (if length≠0), then go to LEADER. If LEADER_BYTES=0, go directly to SYNC.
- Bit encoding, per bit b, MSB first: first half-bit drives ~b, second half-bit drives b. A byte is 16 half-bits.
- LEADER: send LEADER_BYTES bytes of 0x00, then go to SYNC. SYNC: send SYNC_BYTE, then go to DATA. If length=0, go to FINISH instead.
- DATA: the shift register loads from the prefetch buffer at each byte boundary. A new fetch is issued immediately after the load while bytes remain. rd_addr = base + byte index, using 25-bit wrap-around arithmetic.
- Prefetch buffer empty at a byte boundary: set underrun, then hold tape_out at its current level with the half-bit counter frozen until rd_ack. On rd_ack, load the byte in the same clk and resume with a fresh half-bit.
- FINISH: drive tape_out=0, pulse done for 1 clk, then go to IDLE.
- stop, in any state: on the next clk go to IDLE, with tape_out=0, rd_req=0, no done pulse, and underrun retained. An outstanding rd_ack that arrives after the abort is ignored.
- start while busy: ignored. start and stop in the same clk: stop wins.
- rd_ack while rd_req=0: ignored.

## Timing
- Reset values: rd_req=0, rd_addr=0, tape_out=0, busy=0, done=0, underrun=0; state=IDLE.
- First leader half-bit begins on the first ce at or after the clk following start. tape_out changes only on ce boundaries, except when resuming from a stall.
- Half-bit duration = HALF_BIT_CYCLES ce ticks exactly. Byte = 16×HALF_BIT_CYCLES ticks.
- done is asserted 1 clk after the last half-bit's final ce. busy drops in the same clk as done.
- rd_req is asserted in the clk after the shift-register load, and deasserts in the clk after rd_ack.
- Total ce ticks from start to done, with no stalls: 16·HALF_BIT_CYCLES·(LEADER_BYTES+1+length).

## Configuration
- TAPE_PAUSE_EN: when defined, adds input `pause` (1 bit). While pause=1, the half-bit counter is frozen and tape_out holds its level. Fetches still complete. busy stays 1 and stop still works.
- Without TAPE_PAUSE_EN: no `pause` port, and timing never freezes except on an underrun stall.

## Structure
- Package `tape_pkg`: state enum `tape_state_t`, constant `HALF_BITS_PER_BYTE=16`, and the default SYNC_BYTE constant.
- Sub-module `tape_bit_enc`: shift register, half-bit counter and Manchester output. Ports: load, byte, ce, freeze, byte_done. The top level owns the FSM and the fetch handshake.

## Test plan
Unless stated otherwise, the bench uses HALF_BIT_CYCLES=4, LEADER_BYTES=2, and ce held at 1.
- Normal playback, base=0x100, length=2, mem=0xA5,0x3C: tape_out carries 00,00,E6,A5,3C with the specified half-bit pattern. Fetches go to 0x100 and 0x101. done fires 1 clk after 320 ticks. underrun=0.
- length=0: waveform carries 00,00,E6. done fires after 192 ticks. rd_req never asserts.
- rd_ack withheld for 100 clks at the second data byte: underrun=1, and tape_out stays flat for the whole stall. After rd_ack, the remaining waveform is intact and total duration grows by exactly the stall length.
- stop asserted mid-SYNC: next clk shows busy=0, tape_out=0, rd_req=0, and no done. A subsequent start replays from the leader.
- start and stop in the same clk from IDLE: no playback. start while busy: ignored, and the waveform is unchanged.
- reset_n=0 asserted mid-DATA: the next clk shows all outputs at their reset values. With TAPE_PAUSE_EN, pause held for 50 clks stretches the current half-bit by exactly 50 clks.
